// File: rtl/mac_pe_db_if.sv
// Stream bundle between neighbouring processing elements in the MMU array.
// The same bundle carries the west/north inputs into a PE (slave side)
// and the registered east/south outputs out of it (master side).
interface mac_pe_db_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] ifmap;
    logic                  ifmap_valid;
    logic [DATA_WIDTH-1:0] weight;
    logic                  weight_load;
    logic                  weight_swap;
    logic [PSUM_WIDTH-1:0] psum;
    logic                  psum_valid;

    // Producer side: drives the whole bundle.
    modport master (
        output ifmap,
        output ifmap_valid,
        output weight,
        output weight_load,
        output weight_swap,
        output psum,
        output psum_valid
    );

    // Consumer side: samples the whole bundle.
    modport slave (
        input ifmap,
        input ifmap_valid,
        input weight,
        input weight_load,
        input weight_swap,
        input psum,
        input psum_valid
    );
endinterface

// File: rtl/mac_pe_db.sv
// Weight-stationary systolic MAC processing element with a double-buffered
// weight. A new weight shifts down the column into the shadow register while
// the active weight keeps computing; a swap pulse commits shadow to active.
// Supports runtime signed/unsigned operands, valid-qualified ifmap and psum
// streams with bubble passthrough, optional saturation and a sticky overflow
// flag. Every output is registered, giving one cycle per hop in the array.
// PSUM_WIDTH must be at least 2*DATA_WIDTH+1 so a full product always fits.
module mac_pe_db #(
    parameter int DATA_WIDTH = 8,
    parameter int PSUM_WIDTH = 32,
    parameter bit SAT_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         signed_i,
    input  logic         clear_i,
    mac_pe_db_if.slave   upstream,
    mac_pe_db_if.master  downstream,
    output logic         ovf_o
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;
    // Two guard bits above the psum width: enough to hold any signed or
    // unsigned sum of a product and a psum without losing its true value.
    localparam int EXT_WIDTH  = PSUM_WIDTH + 2;
    localparam int TOP_WIDTH  = EXT_WIDTH - PSUM_WIDTH + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] active_q;
    logic [DATA_WIDTH-1:0] ifmap_q;
    logic                  ifmap_valid_q;
    logic                  weight_load_q;
    logic                  weight_swap_q;
    logic [PSUM_WIDTH-1:0] psum_q;
    logic                  psum_valid_q;
    logic                  ovf_q;

    // ------------------------------------------------------------------
    // Datapath signals
    // ------------------------------------------------------------------
    logic [PROD_WIDTH-1:0] op_ifmap;
    logic [PROD_WIDTH-1:0] op_weight;
    logic [PROD_WIDTH-1:0] product;
    logic [EXT_WIDTH-1:0]  product_ext;
    logic [EXT_WIDTH-1:0]  psum_ext;
    logic [EXT_WIDTH-1:0]  sum;
    logic [TOP_WIDTH-1:0]  sum_top;
    logic                  overflow;
    logic [PSUM_WIDTH-1:0] sat_value;
    logic [PSUM_WIDTH-1:0] fit_value;

    // Multiply, extend, add and range-fit the accumulate result.
    // NOTE: every signal assigned here gets a value on every path (defaults
    // first), otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        op_ifmap    = '0;
        op_weight   = '0;
        product     = '0;
        product_ext = '0;
        psum_ext    = '0;
        sum         = '0;
        sum_top     = '0;
        overflow    = 1'b0;
        sat_value   = '0;
        fit_value   = '0;

        // Operands are widened to the product width first so a single
        // multiplier serves both modes: the low 2*DATA_WIDTH bits of a
        // product of sign-extended operands are the signed product.
        op_ifmap  = {{DATA_WIDTH{signed_i & upstream.ifmap[DATA_WIDTH-1]}},
                     upstream.ifmap};
        op_weight = {{DATA_WIDTH{signed_i & active_q[DATA_WIDTH-1]}},
                     active_q};
        product   = op_ifmap * op_weight;

        product_ext = {{(EXT_WIDTH-PROD_WIDTH){signed_i & product[PROD_WIDTH-1]}},
                       product};
        if (upstream.psum_valid) begin
            psum_ext = {{(EXT_WIDTH-PSUM_WIDTH){signed_i & upstream.psum[PSUM_WIDTH-1]}},
                        upstream.psum};
        end
        sum = product_ext + psum_ext;

        // Signed results fit when the bits from the psum sign bit upward
        // all agree; unsigned results fit when nothing lands above the psum.
        sum_top = sum[EXT_WIDTH-1:PSUM_WIDTH-1];
        if (signed_i) begin
            overflow = (sum_top != '0) && (sum_top != '1);
        end else begin
            overflow = |sum[EXT_WIDTH-1:PSUM_WIDTH];
        end

        // Unsigned sums are never negative, so the only unsigned bound to
        // clamp to is the top one.
        if (signed_i) begin
            sat_value = sum[EXT_WIDTH-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                         : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        end else begin
            sat_value = '1;
        end

        if (overflow && SAT_EN) begin
            fit_value = sat_value;
        end else begin
            fit_value = sum[PSUM_WIDTH-1:0];
        end
    end

    // Forward ifmap and the weight-chain controls one hop, every cycle.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their pre-edge inputs, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifmap_q       <= '0;
            ifmap_valid_q <= 1'b0;
            weight_load_q <= 1'b0;
            weight_swap_q <= 1'b0;
        end else begin
            ifmap_q       <= upstream.ifmap;
            ifmap_valid_q <= upstream.ifmap_valid;
            weight_load_q <= upstream.weight_load;
            weight_swap_q <= upstream.weight_swap;
        end
    end

    // Shadow weight shifts in on load; active weight takes the pre-edge
    // shadow on swap, so a simultaneous load and swap moves the old shadow.
    // NOTE: the weights are plain registers, not a storage array, so they are
    // reset like any other state and a reset leaves no stale tile behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (upstream.weight_load) begin
                shadow_q <= upstream.weight;
            end
            if (upstream.weight_swap) begin
                active_q <= shadow_q;
            end
        end
    end

    // Accumulate on a valid ifmap, pass psum through on a bubble, else idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            psum_q       <= '0;
            psum_valid_q <= 1'b0;
        end else if (upstream.ifmap_valid) begin
            psum_q       <= fit_value;
            psum_valid_q <= 1'b1;
        end else if (upstream.psum_valid) begin
            psum_q       <= upstream.psum;
            psum_valid_q <= 1'b1;
        end else begin
            psum_valid_q <= 1'b0;
        end
    end

    // Sticky overflow flag; a fresh overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (upstream.ifmap_valid && overflow) begin
            ovf_q <= 1'b1;
        end else if (clear_i) begin
            ovf_q <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all straight from registers.
    // ------------------------------------------------------------------
    assign downstream.ifmap       = ifmap_q;
    assign downstream.ifmap_valid = ifmap_valid_q;
    assign downstream.weight      = shadow_q;
    assign downstream.weight_load = weight_load_q;
    assign downstream.weight_swap = weight_swap_q;
    assign downstream.psum        = psum_q;
    assign downstream.psum_valid  = psum_valid_q;
    assign ovf_o                  = ovf_q;

endmodule

// File: tb/tb_mac_pe_db.sv
// Scoreboard bench for mac_pe_db. Two instances share one input bundle: one
// saturating, one wrapping. The driver pushes hand-computed results into a
// queue; the monitor pops and compares whenever a psum comes out.
module tb_mac_pe_db;

    typedef struct packed {
        logic [31:0] psum_sat;
        logic [31:0] psum_wrap;
        logic        ovf_sat;
        logic        ovf_wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic signed_mode;
    logic clear;
    logic ovf_sat;
    logic ovf_wrap;
    logic mon_en;

    int n_vec = 0;
    int n_bad = 0;
    exp_t exp_q[$];

    mac_pe_db_if #(.DATA_WIDTH(8), .PSUM_WIDTH(32)) up_if ();
    mac_pe_db_if #(.DATA_WIDTH(8), .PSUM_WIDTH(32)) dn_sat ();
    mac_pe_db_if #(.DATA_WIDTH(8), .PSUM_WIDTH(32)) dn_wrap ();

    mac_pe_db #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .SAT_EN(1'b1)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .signed_i   (signed_mode),
        .clear_i    (clear),
        .upstream   (up_if),
        .downstream (dn_sat),
        .ovf_o      (ovf_sat)
    );

    mac_pe_db #(.DATA_WIDTH(8), .PSUM_WIDTH(32), .SAT_EN(1'b0)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .signed_i   (signed_mode),
        .clear_i    (clear),
        .upstream   (up_if),
        .downstream (dn_wrap),
        .ovf_o      (ovf_wrap)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endfunction

    // Queue a result for both instances.
    task automatic expect_out(input logic [31:0] ps_sat, input logic [31:0] ps_wrap,
                              input logic ov_sat, input logic ov_wrap);
        exp_q.push_back('{ps_sat, ps_wrap, ov_sat, ov_wrap});
    endtask

    task automatic expect_same(input logic [31:0] ps, input logic ov);
        expect_out(ps, ps, ov, ov);
    endtask

    // Apply one cycle of stimulus at a falling edge; return one cycle later.
    task automatic cyc(input logic ifv, input logic [7:0] ifm,
                       input logic pv, input logic [31:0] ps,
                       input logic wl, input logic [7:0] w, input logic ws,
                       input logic sg, input logic clr);
        up_if.ifmap_valid = ifv;
        up_if.ifmap       = ifm;
        up_if.psum_valid  = pv;
        up_if.psum        = ps;
        up_if.weight_load = wl;
        up_if.weight      = w;
        up_if.weight_swap = ws;
        signed_mode       = sg;
        clear             = clr;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_psum_sat"},        dn_sat.psum, 32'd0);
        check({tag, "_psum_valid_sat"},  32'(dn_sat.psum_valid), 32'd0);
        check({tag, "_ifmap_sat"},       32'(dn_sat.ifmap), 32'd0);
        check({tag, "_ifmap_valid_sat"}, 32'(dn_sat.ifmap_valid), 32'd0);
        check({tag, "_weight_sat"},      32'(dn_sat.weight), 32'd0);
        check({tag, "_weight_load_sat"}, 32'(dn_sat.weight_load), 32'd0);
        check({tag, "_weight_swap_sat"}, 32'(dn_sat.weight_swap), 32'd0);
        check({tag, "_ovf_sat"},         32'(ovf_sat), 32'd0);
        check({tag, "_psum_wrap"},       dn_wrap.psum, 32'd0);
        check({tag, "_psum_valid_wrap"}, 32'(dn_wrap.psum_valid), 32'd0);
        check({tag, "_weight_wrap"},     32'(dn_wrap.weight), 32'd0);
        check({tag, "_ovf_wrap"},        32'(ovf_wrap), 32'd0);
    endtask

    // Monitor: every presented psum must match the oldest queued result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en === 1'b1 &&
                (dn_sat.psum_valid === 1'b1 || dn_wrap.psum_valid === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_psum: got valid psum 0x%08h/0x%08h, required no output",
                             dn_sat.psum, dn_wrap.psum);
                end else begin
                    e = exp_q.pop_front();
                    check("psum_valid_sat",  32'(dn_sat.psum_valid), 32'd1);
                    check("psum_valid_wrap", 32'(dn_wrap.psum_valid), 32'd1);
                    check("psum_sat",        dn_sat.psum, e.psum_sat);
                    check("psum_wrap",       dn_wrap.psum, e.psum_wrap);
                    check("ovf_sat",         32'(ovf_sat), 32'(e.ovf_sat));
                    check("ovf_wrap",        32'(ovf_wrap), 32'(e.ovf_wrap));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required end of stimulus");
        $fatal(1, "bench did not finish");
    end

    // Driver: directed vectors with hand-computed results.
    initial begin
        mon_en = 1'b0;
        rst    = 1'b1;
        cyc(1'b1, 8'($urandom), 1'b1, $urandom, 1'b1, 8'($urandom), 1'b1,
            1'($urandom), 1'($urandom));
        check_all_zero("reset1");
        cyc(1'b1, 8'($urandom), 1'b1, $urandom, 1'b1, 8'($urandom), 1'b1,
            1'($urandom), 1'($urandom));
        check_all_zero("reset2");
        rst    = 1'b0;
        mon_en = 1'b1;
        idle();
        check("post_reset_valid", 32'(dn_sat.psum_valid), 32'd0);
        check("post_reset_weight", 32'(dn_sat.weight), 32'd0);

        // Load 5 then 7, swap, then 3*7+10.
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0);
        check("load1_weight_o", 32'(dn_sat.weight), 32'd5);
        check("load1_weight_load_o", 32'(dn_sat.weight_load), 32'd1);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
        check("load2_weight_o", 32'(dn_sat.weight), 32'd7);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        check("swap_weight_load_o", 32'(dn_sat.weight_load), 32'd0);
        check("swap_weight_swap_o", 32'(dn_sat.weight_swap), 32'd1);
        expect_same(32'd31, 1'b0);
        cyc(1'b1, 8'd3, 1'b1, 32'd10, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        check("fwd_ifmap_o", 32'(dn_sat.ifmap), 32'd3);
        check("fwd_ifmap_valid_o", 32'(dn_sat.ifmap_valid), 32'd1);
        check("fwd_weight_swap_o", 32'(dn_sat.weight_swap), 32'd0);

        // Collisions: active=2, shadow=9, then load 4 + swap + MAC.
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
        expect_same(32'd2, 1'b0);
        cyc(1'b1, 8'd1, 1'b1, 32'd0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
        check("collide_shadow", 32'(dn_sat.weight), 32'd4);
        expect_same(32'd9, 1'b0);
        cyc(1'b1, 8'd1, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        // Bubbles: passthrough 42, then 2*3 with no psum, then idle.
        expect_same(32'd42, 1'b0);
        cyc(1'b0, 8'd0, 1'b1, 32'd42, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        expect_same(32'd6, 1'b0);
        cyc(1'b1, 8'd2, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        idle();
        check("idle_valid_sat", 32'(dn_sat.psum_valid), 32'd0);
        check("idle_hold_sat", dn_sat.psum, 32'd6);
        check("idle_hold_wrap", dn_wrap.psum, 32'd6);

        // Signed/unsigned with active = 0x80.
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
        expect_same(32'd16383, 1'b0);
        cyc(1'b1, 8'h80, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        expect_out(32'hFFFF_FFFF, 32'h0000_3FFF, 1'b1, 1'b1);
        cyc(1'b1, 8'h80, 1'b1, 32'hFFFF_FFFF, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        expect_same(32'd133, 1'b1);
        cyc(1'b1, 8'd1, 1'b1, 32'd5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        expect_same(32'd7, 1'b1);
        cyc(1'b0, 8'd0, 1'b1, 32'd7, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
        check("clear_alone_sat", 32'(ovf_sat), 32'd0);
        check("clear_alone_wrap", 32'(ovf_wrap), 32'd0);

        // Signed saturation with active = 10.
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b1, 8'd10, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0);
        expect_out(32'h7FFF_FFFF, 32'h8000_0054, 1'b1, 1'b1);
        cyc(1'b1, 8'd10, 1'b1, 32'h7FFF_FFF0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        expect_same(32'd15, 1'b1);
        cyc(1'b1, 8'd1, 1'b1, 32'd5, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        expect_out(32'h7FFF_FFFF, 32'h8000_0054, 1'b1, 1'b1);
        cyc(1'b1, 8'd10, 1'b1, 32'h7FFF_FFF0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        expect_same(32'd10, 1'b0);
        cyc(1'b1, 8'd1, 1'b1, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        // Negative bound: -10*10 + -2^31.
        expect_out(32'h8000_0000, 32'h7FFF_FF9C, 1'b1, 1'b1);
        cyc(1'b1, 8'hF6, 1'b1, 32'h8000_0000, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 8'd0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
        check("clear2_sat", 32'(ovf_sat), 32'd0);
        // Bubble with overflowing operands present: no MAC, no flag.
        expect_same(32'h7FFF_FFF0, 1'b0);
        cyc(1'b0, 8'd10, 1'b1, 32'h7FFF_FFF0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        check("bubble_ifmap_o", 32'(dn_sat.ifmap), 32'd10);
        check("bubble_ifmap_valid_o", 32'(dn_sat.ifmap_valid), 32'd0);
        // Valid ifmap, no psum: -1*10 signed, 255*10 unsigned.
        expect_same(32'hFFFF_FFF6, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 32'h1234_5678, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
        expect_same(32'd2550, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, 32'h1234_5678, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
        expect_out(32'h7FFF_FFFF, 32'h8000_0054, 1'b1, 1'b1);
        cyc(1'b1, 8'd10, 1'b1, 32'h7FFF_FFF0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);

        // Mid-stream reset discards everything, including the active weight.
        rst = 1'b1;
        cyc(1'b1, 8'd5, 1'b1, 32'd3, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        check_all_zero("midreset");
        rst = 1'b0;
        expect_same(32'd0, 1'b0);
        cyc(1'b1, 8'd3, 1'b0, 32'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

        idle();
        idle();
        check("drain_valid", 32'(dn_sat.psum_valid), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
